// File: rtl/l1_fwd_responder.sv
// l1_fwd_responder: behavioural L1 endpoint answering NoC2 INV/LOAD/STORE forwards with NoC3 FWDACKs after a programmable delay.
// Ports: clk/rst (sync, active-high); chipid/coreid_x/coreid_y own id for the response source flit;
// noc2_valid_in/noc2_data_in/noc2_ready_in request flit channel; noc3_valid_out/noc3_data_out/noc3_ready_out response flit channel;
// resp_delay idle cycles before the first response flit; data_pattern base value of data flits;
// busy high outside RX_HDR; rsp_cnt completed responses (wraps); drop_cnt dropped requests (saturates).
module l1_fwd_responder #(
  parameter logic [7:0] INV_FWD_T      = 8'd18,
  parameter logic [7:0] LOAD_FWD_T     = 8'd16,
  parameter logic [7:0] STORE_FWD_T    = 8'd17,
  parameter logic [7:0] INV_FWDACK_T   = 8'd24,
  parameter logic [7:0] LOAD_FWDACK_T  = 8'd22,
  parameter logic [7:0] STORE_FWDACK_T = 8'd23,
  parameter int         DATA_FLITS     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] chipid,
  input  logic [7:0]  coreid_x,
  input  logic [7:0]  coreid_y,
  input  logic        noc2_valid_in,
  input  logic [63:0] noc2_data_in,
  output logic        noc2_ready_in,
  output logic        noc3_valid_out,
  output logic [63:0] noc3_data_out,
  input  logic        noc3_ready_out,
  input  logic [7:0]  resp_delay,
  input  logic [63:0] data_pattern,
  output logic        busy,
  output logic [15:0] rsp_cnt,
  output logic [7:0]  drop_cnt
);
  typedef enum logic [3:0] {RX_HDR, RX_ADDR, RX_SRC, RX_DRAIN, WAIT, TX_HDR, TX_ADDR, TX_SRC, TX_DATA} state_t;
  state_t state, next, fin;
  logic [7:0] len, ack, mshr, rem, cnt, h_len, h_type;
  logic [39:0] addr;
  logic [29:0] src;
  logic [3:0] k;
  logic inv, drop, short_req, rx_fire, tx_fire, done, last_data, h_ok;
  assign h_len = noc2_data_in[29:22];
  assign h_type = noc2_data_in[21:14];
  assign h_ok = h_type == INV_FWD_T || h_type == LOAD_FWD_T || h_type == STORE_FWD_T;
  assign noc2_ready_in = state == RX_HDR || state == RX_ADDR || state == RX_SRC || state == RX_DRAIN;
  // gated by rst so nothing is offered during the reset cycle itself
  assign noc3_valid_out = !rst && (state == TX_HDR || state == TX_ADDR || state == TX_SRC || state == TX_DATA);
  assign busy = state != RX_HDR;
  assign rx_fire = noc2_valid_in && noc2_ready_in;
  assign tx_fire = noc3_valid_out && noc3_ready_out;
  assign done = rx_fire && ((state == RX_SRC && len <= 8'd2) || (state == RX_DRAIN && rem == 8'd1));
  assign last_data = state == TX_DATA && k == 4'(DATA_FLITS - 1);
  // short requests were already counted at the header; they just go home
  assign fin = (drop || short_req) ? RX_HDR : WAIT;
  always_comb begin
    noc3_data_out = '0;
    case (state)
      TX_HDR:  noc3_data_out = {src, 4'b0, inv ? 8'd2 : 8'(2 + DATA_FLITS), ack, mshr, 6'b0};
      TX_ADDR: noc3_data_out = {24'b0, addr};
      TX_SRC:  noc3_data_out = {chipid, coreid_x, coreid_y, 34'b0};
      TX_DATA: noc3_data_out = data_pattern + 64'(k);
      default: noc3_data_out = '0;
    endcase
  end
  always_comb begin
    next = state;
    case (state)
      RX_HDR:   if (rx_fire) next = h_len == 8'd0 ? RX_HDR : h_len == 8'd1 ? RX_DRAIN : RX_ADDR;
      RX_ADDR:  if (rx_fire) next = RX_SRC;
      RX_SRC:   if (rx_fire) next = len > 8'd2 ? RX_DRAIN : fin;
      RX_DRAIN: if (rx_fire && rem == 8'd1) next = fin;
      WAIT:     if (cnt == 8'd0) next = TX_HDR;
      TX_HDR:   if (tx_fire) next = TX_ADDR;
      TX_ADDR:  if (tx_fire) next = TX_SRC;
      TX_SRC:   if (tx_fire) next = inv ? RX_HDR : TX_DATA;
      TX_DATA:  if (tx_fire && last_data) next = RX_HDR;
      default:  next = RX_HDR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_HDR;
      len <= '0;
      ack <= '0;
      mshr <= '0;
      rem <= '0;
      cnt <= '0;
      addr <= '0;
      src <= '0;
      k <= '0;
      inv <= 1'b0;
      drop <= 1'b0;
      short_req <= 1'b0;
      rsp_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      state <= next;
      if (state == RX_HDR && rx_fire) begin
        len <= h_len;
        mshr <= noc2_data_in[13:6];
        ack <= h_type == INV_FWD_T ? INV_FWDACK_T : h_type == LOAD_FWD_T ? LOAD_FWDACK_T : STORE_FWDACK_T;
        inv <= h_type == INV_FWD_T;
        drop <= !h_ok && h_len >= 8'd2;
        short_req <= h_len < 8'd2;
        rem <= h_len;
      end
      if (state == RX_ADDR && rx_fire) addr <= noc2_data_in[39:0];
      if (state == RX_SRC && rx_fire) begin
        src <= noc2_data_in[63:34];
        rem <= len - 8'd2;
      end
      if (state == RX_DRAIN && rx_fire) rem <= rem - 8'd1;
      cnt <= done ? resp_delay : (state == WAIT && cnt != 8'd0) ? cnt - 8'd1 : cnt;
      k <= state == TX_SRC ? 4'd0 : (state == TX_DATA && tx_fire) ? k + 4'd1 : k;
      if (tx_fire && ((state == TX_SRC && inv) || last_data)) rsp_cnt <= rsp_cnt + 16'd1;
      if (drop_cnt != 8'hFF && ((state == RX_HDR && rx_fire && h_len < 8'd2) || (done && drop)))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_l1_fwd_responder.sv
// tb_l1_fwd_responder: directed self-checking bench for l1_fwd_responder.
module tb_l1_fwd_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic [13:0] chipid = 14'h0AB;
  logic [7:0] coreid_x = 8'h11, coreid_y = 8'h22;
  logic noc2_valid_in = 1'b0, noc2_ready_in, noc3_valid_out, noc3_ready_out = 1'b1, busy;
  logic [63:0] noc2_data_in = '0, noc3_data_out, data_pattern = '0;
  logic [7:0] resp_delay = '0, drop_cnt;
  logic [15:0] rsp_cnt;
  int checks = 0, errors = 0, cyc = 0, t_last = 0;
  logic [63:0] own = {14'h0AB, 8'h11, 8'h22, 34'd0};

  l1_fwd_responder dut (
    .clk(clk), .rst(rst), .chipid(chipid), .coreid_x(coreid_x), .coreid_y(coreid_y),
    .noc2_valid_in(noc2_valid_in), .noc2_data_in(noc2_data_in), .noc2_ready_in(noc2_ready_in),
    .noc3_valid_out(noc3_valid_out), .noc3_data_out(noc3_data_out), .noc3_ready_out(noc3_ready_out),
    .resp_delay(resp_delay), .data_pattern(data_pattern), .busy(busy), .rsp_cnt(rsp_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rsp_hdr(input logic [29:0] s, input logic [7:0] l, input logic [7:0] t, input logic [7:0] m);
    return {s, 4'd0, l, t, m, 6'd0};
  endfunction

  task automatic send(input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    noc2_valid_in = 1'b1;
    noc2_data_in = d;
    while (!noc2_ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready", {63'd0, noc2_ready_in}, 64'd1);
    t_last = cyc;
  endtask

  task automatic req(input logic [7:0] typ, input logic [7:0] len, input logic [7:0] m, input logic [39:0] a, input logic [29:0] s);
    send({30'd0, 4'd0, len, typ, m, 6'd0});
    for (int i = 0; i < int'(len); i++)
      send(i == 0 ? {24'd0, a} : i == 1 ? {s, 34'd0} : 64'hDEAD_0000 + 64'(i));
    @(negedge clk);
    noc2_valid_in = 1'b0;
  endtask

  task automatic get_flit(output logic [63:0] d, output int c);
    int n = 0;
    @(negedge clk);
    while (!noc3_valid_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tx_valid", {63'd0, noc3_valid_out}, 64'd1);
    d = noc3_data_out;
    c = cyc;
  endtask

  initial begin
    logic [63:0] f;
    logic [63:0] got[$];
    logic pv, pr, seen;
    logic [63:0] pd;
    int c0, c1, c2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {63'd0, noc2_ready_in}, 64'd1);
    chk("rst_valid", {63'd0, noc3_valid_out}, 64'd0);
    chk("rst_data", noc3_data_out, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rsp", 64'(rsp_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);

    req(8'd18, 8'd2, 8'h5A, 40'h12_3456_7890, {14'd3, 8'd4, 8'd5});
    get_flit(f, c0);
    chk("inv_lat", 64'(c0 - t_last), 64'd2);
    chk("inv_hdr", f, rsp_hdr({14'd3, 8'd4, 8'd5}, 8'd2, 8'd24, 8'h5A));
    get_flit(f, c1);
    chk("inv_addr", f, {24'd0, 40'h12_3456_7890});
    chk("inv_consec1", 64'(c1 - c0), 64'd1);
    get_flit(f, c2);
    chk("inv_own", f, own);
    chk("inv_consec2", 64'(c2 - c0), 64'd2);
    @(negedge clk);
    chk("inv_rsp", 64'(rsp_cnt), 64'd1);
    chk("inv_idle", {63'd0, busy}, 64'd0);

    resp_delay = 8'd5;
    data_pattern = 64'hFFFF_FFFF_FFFF_FFFF;
    req(8'd16, 8'd2, 8'h33, 40'hAB_CDEF_0123, {14'd9, 8'd1, 8'd2});
    get_flit(f, c0);
    chk("ld_lat", 64'(c0 - t_last), 64'd7);
    chk("ld_hdr", f, rsp_hdr({14'd9, 8'd1, 8'd2}, 8'd4, 8'd22, 8'h33));
    get_flit(f, c1);
    chk("ld_addr", f, {24'd0, 40'hAB_CDEF_0123});
    get_flit(f, c1);
    chk("ld_own", f, own);
    get_flit(f, c1);
    chk("ld_d0", f, 64'hFFFF_FFFF_FFFF_FFFF);
    get_flit(f, c1);
    chk("ld_d1", f, 64'h0);
    @(negedge clk);
    chk("ld_rsp", 64'(rsp_cnt), 64'd2);

    resp_delay = 8'd1;
    data_pattern = 64'h1234_0000_0000_00FF;
    req(8'd17, 8'd2, 8'hC3, 40'h00_0000_0040, {14'd1, 8'd2, 8'd3});
    pv = 1'b0;
    pr = 1'b1;
    pd = '0;
    for (int i = 0; i < 60 && got.size() < 5; i++) begin
      @(negedge clk);
      noc3_ready_out = (i % 3 == 0);
      if (pv && !pr) begin
        chk("st_hold_valid", {63'd0, noc3_valid_out}, 64'd1);
        chk("st_hold_data", noc3_data_out, pd);
      end
      if (noc3_valid_out && noc3_ready_out) got.push_back(noc3_data_out);
      pv = noc3_valid_out;
      pr = noc3_ready_out;
      pd = noc3_data_out;
    end
    @(negedge clk);
    noc3_ready_out = 1'b1;
    chk("st_count", 64'(got.size()), 64'd5);
    chk("st_after", {63'd0, noc3_valid_out}, 64'd0);
    if (got.size() == 5) begin
      chk("st_hdr", got[0], rsp_hdr({14'd1, 8'd2, 8'd3}, 8'd4, 8'd23, 8'hC3));
      chk("st_addr", got[1], {24'd0, 40'h00_0000_0040});
      chk("st_own", got[2], own);
      chk("st_d0", got[3], 64'h1234_0000_0000_00FF);
      chk("st_d1", got[4], 64'h1234_0000_0000_0100);
    end
    chk("st_rsp", 64'(rsp_cnt), 64'd3);

    resp_delay = 8'd0;
    req(8'h07, 8'd3, 8'h01, 40'h1, {14'd1, 8'd1, 8'd1});
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | noc3_valid_out;
    end
    chk("bad_novalid", {63'd0, seen}, 64'd0);
    chk("bad_drop", 64'(drop_cnt), 64'd1);
    chk("bad_busy", {63'd0, busy}, 64'd0);
    chk("bad_rsp", 64'(rsp_cnt), 64'd3);

    for (int i = 0; i < 256; i++) begin
      req(8'd18, 8'd0, 8'h00, 40'h0, 30'd0);
      if (i == 199) chk("sat_mid", 64'(drop_cnt), 64'd201);
    end
    chk("sat_drop", 64'(drop_cnt), 64'd255);
    chk("sat_busy", {63'd0, busy}, 64'd0);
    req(8'd18, 8'd2, 8'h77, 40'h0F_0000_0001, {14'd2, 8'd3, 8'd4});
    get_flit(f, c0);
    chk("sat_hdr", f, rsp_hdr({14'd2, 8'd3, 8'd4}, 8'd2, 8'd24, 8'h77));
    get_flit(f, c0);
    chk("sat_addr", f, {24'd0, 40'h0F_0000_0001});
    get_flit(f, c0);
    chk("sat_own", f, own);
    @(negedge clk);
    chk("sat_rsp", 64'(rsp_cnt), 64'd4);

    req(8'd18, 8'd2, 8'h01, 40'h55, {14'd7, 8'd7, 8'd7});
    get_flit(f, c0);
    @(negedge clk);
    chk("mid_valid", {63'd0, noc3_valid_out}, 64'd1);
    chk("mid_addr", noc3_data_out, {24'd0, 40'h55});
    rst = 1'b1;
    #1;
    chk("rst_cycle_valid", {63'd0, noc3_valid_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_valid", {63'd0, noc3_valid_out}, 64'd0);
    chk("post_ready", {63'd0, noc2_ready_in}, 64'd1);
    chk("post_rsp", 64'(rsp_cnt), 64'd0);
    chk("post_drop", 64'(drop_cnt), 64'd0);
    data_pattern = 64'h10;
    req(8'd16, 8'd2, 8'h99, 40'h44_0000_0000, {14'd5, 8'd6, 8'd7});
    get_flit(f, c0);
    chk("fresh_lat", 64'(c0 - t_last), 64'd2);
    chk("fresh_hdr", f, rsp_hdr({14'd5, 8'd6, 8'd7}, 8'd4, 8'd22, 8'h99));
    get_flit(f, c0);
    chk("fresh_addr", f, {24'd0, 40'h44_0000_0000});
    get_flit(f, c0);
    chk("fresh_own", f, own);
    get_flit(f, c0);
    chk("fresh_d0", f, 64'h10);
    get_flit(f, c0);
    chk("fresh_d1", f, 64'h11);
    @(negedge clk);
    chk("fresh_rsp", 64'(rsp_cnt), 64'd1);
    chk("fresh_busy", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
